// File: rtl/start_done_arbiter_if.sv
// Start/done handshake bundle between the requesters, the arbiter and the shared unit.
// The arbiter uses the slave view; the requester/unit side uses the master view.
interface start_done_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    localparam int OW = $clog2(NREQ);

    logic            enable;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   owner;
    logic            start;
    logic            done;
    logic [NREQ-1:0] req_done;
    logic            busy;
    logic [CNT_W-1:0] count;
    logic            timeout_err;

    modport slave (
        input  enable, req, done,
        output gnt, owner, start, req_done, busy, count, timeout_err
    );

    modport master (
        output enable, req, done,
        input  gnt, owner, start, req_done, busy, count, timeout_err
    );
endinterface

// File: rtl/start_done_arbiter.sv
// Round-robin owner of a shared multi-cycle unit: grant, start pulse, wait for done
// (or time out), completion pulse back to the owner, and a completed-op counter.
module start_done_arbiter #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    start_done_arbiter_if.slave   bus
);
    localparam int OW = $clog2(NREQ);
    localparam int TW = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [OW-1:0]    owner_nxt;
    logic [OW-1:0]    pick_idx;
    logic [OW-1:0]    cand;
    logic             pick_valid;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic [NREQ-1:0]  req_done_nxt;
    logic             start_nxt;
    logic             busy_nxt;
    logic             timeout_err_nxt;

    // Scan starts just past the last owner, so the most recent owner has lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = bus.owner;
        cand       = bus.owner;
        for (int i = 1; i <= NREQ; i++) begin
            cand = OW'((int'(bus.owner) + i) % NREQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        owner_nxt       = bus.owner;
        timer_nxt       = timer;
        count_nxt       = bus.count;
        req_done_nxt    = '0;
        timeout_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && pick_valid) begin
                    state_nxt = ISSUE;
                    owner_nxt = pick_idx;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                timer_nxt = '0;
            end
            WAIT: begin
                timer_nxt = timer + TW'(1);
                // done wins over the timeout on the last allowed cycle.
                if (bus.done) begin
                    state_nxt    = RELEASE;
                    req_done_nxt = NREQ'(1) << bus.owner;
                    count_nxt    = bus.count + CNT_W'(1);
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt       = RELEASE;
                    timeout_err_nxt = 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered with it.
        start_nxt = (state_nxt == ISSUE);
        busy_nxt  = (state_nxt != IDLE);
        gnt_nxt   = (state_nxt == ISSUE || state_nxt == WAIT) ? (NREQ'(1) << owner_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            bus.owner       <= OW'(NREQ - 1);
            bus.gnt         <= '0;
            bus.start       <= 1'b0;
            bus.req_done    <= '0;
            bus.busy        <= 1'b0;
            bus.count       <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            bus.owner       <= owner_nxt;
            bus.gnt         <= gnt_nxt;
            bus.start       <= start_nxt;
            bus.req_done    <= req_done_nxt;
            bus.busy        <= busy_nxt;
            bus.count       <= count_nxt;
            bus.timeout_err <= timeout_err_nxt;
        end
    end
endmodule
